// File: rtl/regfile_dump_ctrl.sv
// ============================================================================
// Module   : regfile_dump_ctrl
// Purpose  : Debug/boot initiator for the three-port register file.
//            Dump mode walks read port 1 over the general registers and
//            streams each word out on a valid/ready source interface.
//            Load mode accepts words on a valid/ready sink interface and
//            writes them through the regfile write port.
//            The core is stalled for the whole operation.
// Options  : REGDUMP_PC_EN - when defined, a dump also returns r15 (PC+8),
//            giving 16 words; load never writes r15 in either build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_ctrl #(
  parameter int DW        = 32,
  parameter int AW        = 4,
  parameter int LAST_ADDR = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  // control
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          stall,
  // regfile read port 1
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  // regfile write port
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  // dump stream source
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  // load stream sink
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RD     = 3'd2,
    ST_OUT    = 3'd3,
    ST_LOAD   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Load never touches the PC register, so its last address is fixed.
  localparam logic [AW-1:0] LOAD_LAST = AW'(LAST_ADDR);
`ifdef REGDUMP_PC_EN
  // Dump also reads back r15, which the regfile returns as PC+8.
  localparam logic [AW-1:0] DUMP_LAST = AW'(LAST_ADDR + 1);
`else
  localparam logic [AW-1:0] DUMP_LAST = AW'(LAST_ADDR);
`endif

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic            mode_q;
  logic            busy_q;
  logic            done_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [DW-1:0]   out_data_q;
  logic [AW-1:0]   out_addr_q;
  logic [AW-1:0]   rf_ra_q;

  // Next walk address; termination is by compare, so this never wraps in use.
  logic [AW-1:0]   addr_d;
  logic            out_fire;
  logic            in_fire;

  assign addr_d   = addr_q + 1'b1;
  assign out_fire = out_valid_q & out_ready;
  // in_ready_q is high exactly while in LOAD, so it also qualifies the write.
  assign in_fire  = in_ready_q & in_valid;

  // Main controller: state, walk address and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      rf_ra_q     <= '0;
    end else begin
      // Single-cycle outputs fall back to 0 unless a branch re-asserts them.
      done_q  <= 1'b0;
      rf_ra_q <= '0;

      if (abort && (state_q != ST_IDLE)) begin
        // Abort drops straight to IDLE; a same-cycle load write still lands
        // through the combinational write port, and no done is produced.
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_SETTLE;
              addr_q  <= '0;
              mode_q  <= mode;
              busy_q  <= 1'b1;
            end
          end

          ST_SETTLE: begin
            // One quiet cycle so the core can drain before we use the ports.
            if (mode_q) begin
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= ST_RD;
              rf_ra_q <= addr_q;
            end
          end

          ST_RD: begin
            // rf_ra_q holds addr_q this cycle; capture the combinational read.
            state_q     <= ST_OUT;
            out_data_q  <= rf_rd;
            out_addr_q  <= addr_q;
            out_valid_q <= 1'b1;
          end

          ST_OUT: begin
            // Word and index stay put until the sink takes them.
            if (out_fire) begin
              out_valid_q <= 1'b0;
              if (addr_q == DUMP_LAST) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_RD;
                addr_q  <= addr_d;
                rf_ra_q <= addr_d;
              end
            end
          end

          ST_LOAD: begin
            if (in_fire) begin
              if (addr_q == LOAD_LAST) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end else begin
                addr_q <= addr_d;
              end
            end
          end

          ST_DONE: begin
            // done_q is high for this cycle only; stall releases on exit.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign stall     = busy_q;
  assign done      = done_q;
  assign rf_ra     = rf_ra_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign in_ready  = in_ready_q;

  // The write port is only ever driven while in LOAD; zero otherwise.
  assign rf_we = in_fire;
  assign rf_wa = in_ready_q ? addr_q  : '0;
  assign rf_wd = in_ready_q ? in_data : '0;

endmodule

`default_nettype wire
